dcache_miss_ctrl: RTL

DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_miss_ctrl_if.sv | 23 ++
 rtl/dcache_fill_buffer.sv | 37 +++
 rtl/dcache_miss_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache miss controller.
// The default line geometry matches the attached data cache.
package dcache_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int WORDS      = BLOCK_SIZE / 32;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_FILL,
    REPAIR,
    LD_RESP,
    ST_MEM
  } state_e;

  // Clears the byte-offset-within-line bits of an address.
  function automatic logic [31:0] line_mask(input int block_size);
    return ~(32'(block_size / 8) - 32'd1);
  endfunction

  localparam logic [31:0] LINE_ADDR_MASK = line_mask(BLOCK_SIZE);

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Memory-side request/response bus of the miss controller.
// master = controller, slave = memory.
interface dcache_miss_ctrl_if;

  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;

  modport master (
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

endinterface

// File: rtl/dcache_fill_buffer.sv
// Refill assembly: places 32-bit beats into a line register in arrival order
// and flags the beat that completes the line.
module dcache_fill_buffer #(
  parameter int BLOCK_SIZE = 128,
  parameter int WORDS      = BLOCK_SIZE / 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_beat_valid,
  input  logic [31:0]           i_beat_data,
  output logic [BLOCK_SIZE-1:0] o_line,
  output logic                  o_last
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_W-1:0]      r_cnt;
  logic [BLOCK_SIZE-1:0] r_line;
  logic                  w_last;

  assign w_last = i_beat_valid && (r_cnt == CNT_W'(WORDS - 1));
  assign o_last = w_last;
  assign o_line = r_line;

  // NOTE: the line register is a plain flop array, so it is cleared on reset
  // like any other state; an abandoned refill must not leave stale beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
    end else if (i_beat_valid) begin
      r_line[32*r_cnt +: 32] <= i_beat_data;
      r_cnt                  <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Blocking data-cache miss controller: 1-cycle load hits, line refill on miss,
// write-through / no-allocate stores, one outstanding memory request.
module dcache_miss_ctrl #(
  parameter int BLOCK_SIZE = dcache_pkg::BLOCK_SIZE,
  parameter int WORDS      = BLOCK_SIZE / 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // core load port
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [31:0]           ld_addr_i,
  output logic                  ld_resp_valid_o,
  output logic [31:0]           ld_resp_data_o,
  // core store port
  input  logic                  st_valid_i,
  output logic                  st_ready_o,
  input  logic [31:0]           st_addr_i,
  input  logic [31:0]           st_data_i,
  output logic                  st_done_o,
  // data cache ports
  output logic                  c_r_en_o,
  output logic [31:0]           c_r_addr_o,
  input  logic [31:0]           c_r_data_i,
  input  logic                  c_r_hit_i,
  output logic                  c_w_en_o,
  output logic [31:0]           c_w_addr_o,
  output logic [31:0]           c_w_data_o,
  output logic                  c_is_repair_o,
  output logic [BLOCK_SIZE-1:0] c_repair_data_o,
  // memory bus
  dcache_miss_ctrl_if.master    mem
);

  import dcache_pkg::state_e;
  import dcache_pkg::IDLE;
  import dcache_pkg::MISS_REQ;
  import dcache_pkg::MISS_FILL;
  import dcache_pkg::REPAIR;
  import dcache_pkg::LD_RESP;
  import dcache_pkg::ST_MEM;
  import dcache_pkg::line_mask;

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0] LINE_MASK =
    (BLOCK_SIZE == dcache_pkg::BLOCK_SIZE) ? dcache_pkg::LINE_ADDR_MASK : line_mask(BLOCK_SIZE);

  state_e                r_state;
  state_e                w_next;
  logic [31:0]           r_addr;
  logic [31:0]           r_data;
  logic                  r_hit_resp;
  logic [31:0]           r_hit_data;
  logic                  r_st_done;

  logic                  w_ld_take;
  logic                  w_st_take;
  logic                  w_hit_take;
  logic                  w_st_done_set;
  logic                  w_beat_valid;
  logic                  w_last;
  logic [BLOCK_SIZE-1:0] w_line;
  logic [CNT_W-1:0]      w_sel;
  logic [31:0]           w_resp_word;
  logic [31:0]           w_line_addr;

  // Beats are only meaningful while a refill is in progress.
  assign w_beat_valid = !rst && (r_state == MISS_FILL) && mem.mem_resp_valid_i;
  assign w_sel        = r_addr[CNT_W+1:2];
  assign w_resp_word  = w_line[32*w_sel +: 32];
  assign w_line_addr  = r_addr & LINE_MASK;
  assign c_repair_data_o = w_line;

  dcache_fill_buffer #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .WORDS      (WORDS)
  ) u_fill_buffer (
    .clk          (clk),
    .rst          (rst),
    .i_beat_valid (w_beat_valid),
    .i_beat_data  (mem.mem_resp_data_i),
    .o_line       (w_line),
    .o_last       (w_last)
  );

  // NOTE: all state updates use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_hit_resp <= 1'b0;
      r_hit_data <= '0;
      r_st_done  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hit_resp <= w_hit_take;
      r_st_done  <= w_st_done_set;
      if (w_hit_take) r_hit_data <= c_r_data_i;
      if (w_st_take) begin
        r_addr <= st_addr_i;
        r_data <= st_data_i;
      end else if (w_ld_take) begin
        r_addr <= ld_addr_i;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next               = r_state;
    ld_ready_o           = 1'b0;
    st_ready_o           = 1'b0;
    ld_resp_valid_o      = 1'b0;
    ld_resp_data_o       = r_hit_data;
    st_done_o            = 1'b0;
    c_r_en_o             = 1'b0;
    c_r_addr_o           = '0;
    c_w_en_o             = 1'b0;
    c_w_addr_o           = '0;
    c_w_data_o           = '0;
    c_is_repair_o        = 1'b0;
    mem.mem_req_valid_o  = 1'b0;
    mem.mem_req_we_o     = 1'b0;
    mem.mem_req_addr_o   = '0;
    mem.mem_req_wdata_o  = '0;
    w_ld_take            = 1'b0;
    w_st_take            = 1'b0;
    w_hit_take           = 1'b0;
    w_st_done_set        = 1'b0;

    if (rst) begin
      w_next = IDLE;
    end else begin
      ld_resp_valid_o = r_hit_resp;
      st_done_o       = r_st_done;
      unique case (r_state)
        IDLE: begin
          st_ready_o = 1'b1;
          ld_ready_o = !st_valid_i;
          if (st_valid_i) begin
            // Write-through: the cache updates itself only if the word hits.
            c_w_en_o   = 1'b1;
            c_w_addr_o = st_addr_i;
            c_w_data_o = st_data_i;
            w_st_take  = 1'b1;
            w_next     = ST_MEM;
          end else if (ld_valid_i) begin
            c_r_en_o   = 1'b1;
            c_r_addr_o = ld_addr_i;
            w_ld_take  = 1'b1;
            if (c_r_hit_i) w_hit_take = 1'b1;
            else           w_next     = MISS_REQ;
          end
        end
        MISS_REQ: begin
          mem.mem_req_valid_o = 1'b1;
          mem.mem_req_addr_o  = w_line_addr;
          if (mem.mem_req_ready_i) w_next = MISS_FILL;
        end
        MISS_FILL: begin
          if (w_last) w_next = REPAIR;
        end
        REPAIR: begin
          c_w_en_o      = 1'b1;
          c_is_repair_o = 1'b1;
          c_w_addr_o    = w_line_addr;
          w_next        = LD_RESP;
        end
        LD_RESP: begin
          ld_resp_valid_o = 1'b1;
          ld_resp_data_o  = w_resp_word;
          w_next          = IDLE;
        end
        ST_MEM: begin
          mem.mem_req_valid_o = 1'b1;
          mem.mem_req_we_o    = 1'b1;
          mem.mem_req_addr_o  = r_addr;
          mem.mem_req_wdata_o = r_data;
          if (mem.mem_req_ready_i) begin
            w_st_done_set = 1'b1;
            w_next        = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule
